// File: rtl/psm_ramp_sequencer.sv
// Start/stop and setpoint sequencer for the phase-shift modulator: holds the modulator
// in reset while idle and slews SPS/DPS by a bounded step once per carrier period.
module psm_ramp_sequencer #(
    parameter int unsigned BITS_DATA   = 16,
    parameter int unsigned START_TICKS = 2,
    parameter int unsigned STEP_W      = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 iENABLE,
    input  logic                 iFAULT,
    input  logic                 iCLEAR,
    input  logic                 iPERIOD_TICK,
    input  logic                 iCFG_VALID,
    output logic                 oCFG_READY,
    input  logic [BITS_DATA-1:0] iCFG_SPS,
    input  logic                 iCFG_SPS_SIGN,
    input  logic [BITS_DATA-1:0] iCFG_DPS,
    input  logic                 iCFG_DPS_SIGN,
    input  logic [BITS_DATA-1:0] iCFG_FREQ,
    input  logic [STEP_W-1:0]    iSTEP,
    output logic [BITS_DATA-1:0] oSPS_value,
    output logic                 oSPS_sign,
    output logic [BITS_DATA-1:0] oDPS_value,
    output logic                 oDPS_sign,
    output logic [BITS_DATA-1:0] oFREQUENCY,
    output logic                 oPSM_RST,
    output logic [2:0]           oSTATE,
    output logic                 oBUSY
);

    localparam int unsigned AW    = ((BITS_DATA > STEP_W) ? BITS_DATA : STEP_W) + 1;
    localparam int unsigned CNT_W = (START_TICKS < 2) ? 1 : $clog2(START_TICKS);
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(START_TICKS - 1);
    localparam logic [BITS_DATA-1:0] FREQ_RST = BITS_DATA'(2000);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RAMP  = 3'd2,
        ST_RUN   = 3'd3,
        ST_STOP  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    state_t               r_state;
    logic                 r_psm_rst;
    logic                 r_cfg_ready;
    logic                 r_busy;
    logic [BITS_DATA-1:0] r_sps_val;
    logic                 r_sps_sgn;
    logic [BITS_DATA-1:0] r_dps_val;
    logic                 r_dps_sgn;
    logic [BITS_DATA-1:0] r_freq;
    logic [BITS_DATA-1:0] r_tgt_sps;
    logic                 r_tgt_sps_s;
    logic [BITS_DATA-1:0] r_tgt_dps;
    logic                 r_tgt_dps_s;
    logic [CNT_W-1:0]     r_tick_cnt;

    logic [AW-1:0]        w_step;
    logic [BITS_DATA-1:0] w_lim;
    logic [BITS_DATA-1:0] w_cfg_sps;
    logic [BITS_DATA-1:0] w_cfg_dps;
    logic                 w_cfg_acc;
    logic                 w_cfg_diff;
    logic [BITS_DATA-1:0] w_rt_sps;
    logic                 w_rt_sps_s;
    logic [BITS_DATA-1:0] w_rt_dps;
    logic                 w_rt_dps_s;
    logic [BITS_DATA:0]   w_sps_slew;
    logic [BITS_DATA:0]   w_dps_slew;
    logic [BITS_DATA:0]   w_sps_upd;
    logic [BITS_DATA:0]   w_dps_upd;
    logic                 w_hit;
    logic                 w_zero;
    logic                 w_start_done;

    // Returns {sign, magnitude} after one bounded move toward the target. A sign change
    // first drains the magnitude to zero; the sign flips on the tick that reaches zero.
    function automatic logic [BITS_DATA:0] slew(
        input logic [BITS_DATA-1:0] cur,
        input logic                 cur_s,
        input logic [BITS_DATA-1:0] tgt,
        input logic                 tgt_s,
        input logic [AW-1:0]        step
    );
        logic [AW-1:0] c;
        logic [AW-1:0] t;
        logic [AW-1:0] m;
        logic [AW-1:0] d;
        logic          s;
        c = AW'(cur);
        t = AW'(tgt);
        s = cur_s;
        if (cur_s != tgt_s) begin
            m = (step < c) ? step : c;
            d = c - m;
            if (d == '0) s = tgt_s;
        end else if (c < t) begin
            m = (step < (t - c)) ? step : (t - c);
            d = c + m;
        end else begin
            m = (step < (c - t)) ? step : (c - t);
            d = c - m;
        end
        return {s, d[BITS_DATA-1:0]};
    endfunction

    always_comb begin
        w_step     = (iSTEP == '0) ? AW'(1) : AW'(iSTEP);
        w_lim      = (r_state == ST_IDLE) ? iCFG_FREQ : r_freq;
        w_cfg_sps  = (iCFG_SPS > w_lim) ? w_lim : iCFG_SPS;
        w_cfg_dps  = (iCFG_DPS > w_lim) ? w_lim : iCFG_DPS;
        w_cfg_acc  = iCFG_VALID & r_cfg_ready;
        w_cfg_diff = ({iCFG_SPS_SIGN, w_cfg_sps} != {r_sps_sgn, r_sps_val}) ||
                     ({iCFG_DPS_SIGN, w_cfg_dps} != {r_dps_sgn, r_dps_val});

        // Stopping ramps to zero keeping the present sign; saved targets stay untouched.
        if (r_state == ST_STOP) begin
            w_rt_sps   = '0;
            w_rt_sps_s = r_sps_sgn;
            w_rt_dps   = '0;
            w_rt_dps_s = r_dps_sgn;
        end else begin
            w_rt_sps   = r_tgt_sps;
            w_rt_sps_s = r_tgt_sps_s;
            w_rt_dps   = r_tgt_dps;
            w_rt_dps_s = r_tgt_dps_s;
        end

        w_sps_slew = slew(r_sps_val, r_sps_sgn, w_rt_sps, w_rt_sps_s, w_step);
        w_dps_slew = slew(r_dps_val, r_dps_sgn, w_rt_dps, w_rt_dps_s, w_step);
        w_sps_upd  = iPERIOD_TICK ? w_sps_slew : {r_sps_sgn, r_sps_val};
        w_dps_upd  = iPERIOD_TICK ? w_dps_slew : {r_dps_sgn, r_dps_val};
        w_hit      = (w_sps_upd == {r_tgt_sps_s, r_tgt_sps}) &&
                     (w_dps_upd == {r_tgt_dps_s, r_tgt_dps});
        w_zero     = (w_sps_upd[BITS_DATA-1:0] == '0) && (w_dps_upd[BITS_DATA-1:0] == '0);
        w_start_done = (START_TICKS == 0) || (r_tick_cnt == LAST_TICK);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_psm_rst   <= 1'b1;
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_sps_val   <= '0;
            r_sps_sgn   <= 1'b0;
            r_dps_val   <= '0;
            r_dps_sgn   <= 1'b0;
            r_freq      <= FREQ_RST;
            r_tgt_sps   <= '0;
            r_tgt_sps_s <= 1'b0;
            r_tgt_dps   <= '0;
            r_tgt_dps_s <= 1'b0;
            r_tick_cnt  <= '0;
        end else if (iFAULT) begin
            r_state     <= ST_FAULT;
            r_psm_rst   <= 1'b1;
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_sps_val   <= '0;
            r_sps_sgn   <= 1'b0;
            r_dps_val   <= '0;
            r_dps_sgn   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_sps_val <= '0;
                    r_sps_sgn <= 1'b0;
                    r_dps_val <= '0;
                    r_dps_sgn <= 1'b0;
                    if (w_cfg_acc) begin
                        r_freq      <= iCFG_FREQ;
                        r_tgt_sps   <= w_cfg_sps;
                        r_tgt_sps_s <= iCFG_SPS_SIGN;
                        r_tgt_dps   <= w_cfg_dps;
                        r_tgt_dps_s <= iCFG_DPS_SIGN;
                    end
                    if (iENABLE) begin
                        r_state     <= ST_START;
                        r_psm_rst   <= 1'b0;
                        r_cfg_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_tick_cnt  <= '0;
                    end else begin
                        r_psm_rst   <= 1'b1;
                        r_cfg_ready <= 1'b1;
                    end
                end
                ST_START: begin
                    if (!iENABLE) begin
                        r_state     <= ST_IDLE;
                        r_cfg_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else if (iPERIOD_TICK) begin
                        if (w_start_done) begin
                            r_state     <= ST_RAMP;
                            r_cfg_ready <= 1'b1;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                ST_RAMP: begin
                    if (!iENABLE) begin
                        r_state     <= ST_STOP;
                        r_cfg_ready <= 1'b0;
                    end else begin
                        if (w_cfg_acc) begin
                            r_tgt_sps   <= w_cfg_sps;
                            r_tgt_sps_s <= iCFG_SPS_SIGN;
                            r_tgt_dps   <= w_cfg_dps;
                            r_tgt_dps_s <= iCFG_DPS_SIGN;
                        end
                        r_sps_sgn <= w_sps_upd[BITS_DATA];
                        r_sps_val <= w_sps_upd[BITS_DATA-1:0];
                        r_dps_sgn <= w_dps_upd[BITS_DATA];
                        r_dps_val <= w_dps_upd[BITS_DATA-1:0];
                        // A fresh target lands this cycle; settle against it next cycle.
                        if (!w_cfg_acc && w_hit) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (!iENABLE) begin
                        r_state     <= ST_STOP;
                        r_cfg_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end else if (w_cfg_acc) begin
                        r_tgt_sps   <= w_cfg_sps;
                        r_tgt_sps_s <= iCFG_SPS_SIGN;
                        r_tgt_dps   <= w_cfg_dps;
                        r_tgt_dps_s <= iCFG_DPS_SIGN;
                        if (w_cfg_diff) begin
                            r_state <= ST_RAMP;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (iENABLE) begin
                        r_state     <= ST_RAMP;
                        r_cfg_ready <= 1'b1;
                    end else if (iPERIOD_TICK) begin
                        r_sps_sgn <= w_sps_upd[BITS_DATA];
                        r_sps_val <= w_sps_upd[BITS_DATA-1:0];
                        r_dps_sgn <= w_dps_upd[BITS_DATA];
                        r_dps_val <= w_dps_upd[BITS_DATA-1:0];
                        if (w_zero) begin
                            r_state     <= ST_IDLE;
                            r_cfg_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end
                    end
                end
                ST_FAULT: begin
                    if (iCLEAR) begin
                        r_state     <= ST_IDLE;
                        r_cfg_ready <= 1'b1;
                        r_tgt_sps   <= '0;
                        r_tgt_sps_s <= 1'b0;
                        r_tgt_dps   <= '0;
                        r_tgt_dps_s <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_psm_rst   <= 1'b1;
                    r_cfg_ready <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign oCFG_READY = r_cfg_ready;
    assign oSPS_value = r_sps_val;
    assign oSPS_sign  = r_sps_sgn;
    assign oDPS_value = r_dps_val;
    assign oDPS_sign  = r_dps_sgn;
    assign oFREQUENCY = r_freq;
    assign oPSM_RST   = r_psm_rst;
    assign oSTATE     = r_state;
    assign oBUSY      = r_busy;

endmodule

// File: tb/tb_psm_ramp_sequencer.sv
// Bench for psm_ramp_sequencer: per-cycle expected outputs from a behavioural model are
// queued by the stimulus process and compared by an independent monitor.
module tb_psm_ramp_sequencer;

    localparam int START_TICKS = 2;

    logic        CLK = 1'b0;
    logic        RST, iENABLE, iFAULT, iCLEAR, iPERIOD_TICK, iCFG_VALID;
    logic        oCFG_READY;
    logic [15:0] iCFG_SPS, iCFG_DPS, iCFG_FREQ;
    logic        iCFG_SPS_SIGN, iCFG_DPS_SIGN;
    logic [7:0]  iSTEP;
    logic [15:0] oSPS_value, oDPS_value, oFREQUENCY;
    logic        oSPS_sign, oDPS_sign, oPSM_RST, oBUSY;
    logic [2:0]  oSTATE;

    psm_ramp_sequencer #(.BITS_DATA(16), .START_TICKS(START_TICKS), .STEP_W(8)) dut (
        .CLK(CLK), .RST(RST), .iENABLE(iENABLE), .iFAULT(iFAULT), .iCLEAR(iCLEAR),
        .iPERIOD_TICK(iPERIOD_TICK), .iCFG_VALID(iCFG_VALID), .oCFG_READY(oCFG_READY),
        .iCFG_SPS(iCFG_SPS), .iCFG_SPS_SIGN(iCFG_SPS_SIGN), .iCFG_DPS(iCFG_DPS),
        .iCFG_DPS_SIGN(iCFG_DPS_SIGN), .iCFG_FREQ(iCFG_FREQ), .iSTEP(iSTEP),
        .oSPS_value(oSPS_value), .oSPS_sign(oSPS_sign), .oDPS_value(oDPS_value),
        .oDPS_sign(oDPS_sign), .oFREQUENCY(oFREQUENCY), .oPSM_RST(oPSM_RST),
        .oSTATE(oSTATE), .oBUSY(oBUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int state; bit psm; bit rdy; bit busy;
        int sps; bit sps_s; int dps; bit dps_s; int freq;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;

    // Next-cycle input values; pulses are cleared after each applied cycle.
    bit s_rst, s_en, s_flt, s_clr, s_tk, s_vld, s_sps_s, s_dps_s;
    int s_sps, s_dps, s_freq, s_step;

    // Reference model state, in spec terms.
    exp_t m;
    int   t_sps, t_dps, ticks_seen;
    bit   t_sps_s, t_dps_s;

    task automatic approach(input int mag, input bit sg, input int tm, input bit ts,
                            input int st, output int nm, output bit ns);
        ns = sg;
        if (sg != ts) begin
            nm = (mag > st) ? mag - st : 0;
            if (nm == 0) ns = ts;
        end else if (mag < tm) begin
            nm = (tm - mag > st) ? mag + st : tm;
        end else begin
            nm = (mag - tm > st) ? mag - st : tm;
        end
    endtask

    task automatic model_step();
        bit acc;
        int st, lim, c_sps, c_dps, nm;
        bit ns;
        acc   = s_vld && m.rdy;
        st    = (s_step == 0) ? 1 : s_step;
        lim   = (m.state == 0) ? s_freq : m.freq;
        c_sps = (s_sps > lim) ? lim : s_sps;
        c_dps = (s_dps > lim) ? lim : s_dps;
        if (s_rst) begin
            m = '{state: 0, psm: 1, rdy: 0, busy: 0, sps: 0, sps_s: 0, dps: 0, dps_s: 0, freq: 2000};
            t_sps = 0; t_dps = 0; t_sps_s = 0; t_dps_s = 0; ticks_seen = 0;
        end else if (s_flt) begin
            m.state = 5; m.psm = 1; m.rdy = 0; m.busy = 0;
            m.sps = 0; m.sps_s = 0; m.dps = 0; m.dps_s = 0;
        end else begin
            case (m.state)
                0: begin
                    m.sps = 0; m.sps_s = 0; m.dps = 0; m.dps_s = 0;
                    if (acc) begin
                        m.freq = s_freq;
                        t_sps = c_sps; t_sps_s = s_sps_s; t_dps = c_dps; t_dps_s = s_dps_s;
                    end
                    if (s_en) begin
                        m.state = 1; m.psm = 0; m.rdy = 0; m.busy = 1; ticks_seen = 0;
                    end else begin
                        m.psm = 1; m.rdy = 1;
                    end
                end
                1: begin
                    if (!s_en) begin
                        m.state = 0; m.rdy = 1; m.busy = 0;
                    end else if (s_tk) begin
                        ticks_seen++;
                        if (ticks_seen >= START_TICKS) begin m.state = 2; m.rdy = 1; end
                    end
                end
                2: begin
                    if (!s_en) begin
                        m.state = 4; m.rdy = 0;
                    end else begin
                        if (s_tk) begin
                            approach(m.sps, m.sps_s, t_sps, t_sps_s, st, nm, ns);
                            m.sps = nm; m.sps_s = ns;
                            approach(m.dps, m.dps_s, t_dps, t_dps_s, st, nm, ns);
                            m.dps = nm; m.dps_s = ns;
                        end
                        if (acc) begin
                            t_sps = c_sps; t_sps_s = s_sps_s; t_dps = c_dps; t_dps_s = s_dps_s;
                        end else if (m.sps == t_sps && m.sps_s == t_sps_s &&
                                     m.dps == t_dps && m.dps_s == t_dps_s) begin
                            m.state = 3; m.busy = 0;
                        end
                    end
                end
                3: begin
                    if (!s_en) begin
                        m.state = 4; m.rdy = 0; m.busy = 1;
                    end else if (acc) begin
                        t_sps = c_sps; t_sps_s = s_sps_s; t_dps = c_dps; t_dps_s = s_dps_s;
                        if (m.sps != t_sps || m.sps_s != t_sps_s ||
                            m.dps != t_dps || m.dps_s != t_dps_s) begin
                            m.state = 2; m.busy = 1;
                        end
                    end
                end
                4: begin
                    if (s_en) begin
                        m.state = 2; m.rdy = 1;
                    end else if (s_tk) begin
                        m.sps = (m.sps > st) ? m.sps - st : 0;
                        m.dps = (m.dps > st) ? m.dps - st : 0;
                        if (m.sps == 0 && m.dps == 0) begin m.state = 0; m.rdy = 1; m.busy = 0; end
                    end
                end
                5: begin
                    if (s_clr) begin
                        m.state = 0; m.rdy = 1;
                        t_sps = 0; t_dps = 0; t_sps_s = 0; t_dps_s = 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
        RST = s_rst; iENABLE = s_en; iFAULT = s_flt; iCLEAR = s_clr; iPERIOD_TICK = s_tk;
        iCFG_VALID = s_vld; iCFG_SPS = 16'(s_sps); iCFG_SPS_SIGN = s_sps_s;
        iCFG_DPS = 16'(s_dps); iCFG_DPS_SIGN = s_dps_s; iCFG_FREQ = 16'(s_freq); iSTEP = 8'(s_step);
        model_step();
        exp_q.push_back(m);
        s_rst = 0; s_clr = 0; s_tk = 0; s_vld = 0;
    endtask

    task automatic cfg(input int sps, input bit sps_s, input int dps, input bit dps_s, input int freq);
        s_vld = 1; s_sps = sps; s_sps_s = sps_s; s_dps = dps; s_dps_s = dps_s; s_freq = freq;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            s_tk = 1; cyc(); cyc();
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL cycle=%0d %s got=%0d exp=%0d", cyc_n, name, got, want);
        end
    endtask

    // Monitor: the DUT presents a new registered output set after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            cyc_n++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state", int'(oSTATE), e.state);
                chk("psm_rst", int'(oPSM_RST), int'(e.psm));
                chk("cfg_ready", int'(oCFG_READY), int'(e.rdy));
                chk("busy", int'(oBUSY), int'(e.busy));
                chk("sps_value", int'(oSPS_value), e.sps);
                chk("sps_sign", int'(oSPS_sign), int'(e.sps_s));
                chk("dps_value", int'(oDPS_value), e.dps);
                chk("dps_sign", int'(oDPS_sign), int'(e.dps_s));
                chk("frequency", int'(oFREQUENCY), e.freq);
            end
        end
    end

    initial begin
        RST = 1; iENABLE = 0; iFAULT = 0; iCLEAR = 0; iPERIOD_TICK = 0; iCFG_VALID = 0;
        iCFG_SPS = '0; iCFG_SPS_SIGN = 0; iCFG_DPS = '0; iCFG_DPS_SIGN = 0;
        iCFG_FREQ = '0; iSTEP = '0;
        s_en = 0; s_flt = 0; s_clr = 0; s_tk = 0; s_vld = 0;
        s_sps = 0; s_sps_s = 0; s_dps = 0; s_dps_s = 0; s_freq = 2000; s_step = 100;
        s_rst = 1; cyc(); s_rst = 1; cyc();
        cyc();

        // Start-up ramp: SPS +400 / DPS +100 with step 100.
        cfg(400, 0, 100, 0, 2000); s_step = 100; cyc();
        s_en = 1; cyc(); cyc(); cyc();
        ticks(8);

        // Sign reversal in RUN.
        cfg(150, 1, 100, 0, 2000); cyc();
        ticks(8);

        // Target above the frequency is clamped; FREQ is ignored outside IDLE.
        s_step = 255; cfg(2500, 0, 100, 0, 2000); cyc();
        ticks(12);
        cfg(400, 0, 100, 0, 1000); cyc();
        ticks(10);

        // Ramp-down and stop with step 250.
        s_step = 250; s_en = 0; cyc();
        ticks(3); cyc(); cyc();

        // Fault mid-ramp, clear held off while the fault is present.
        cfg(1000, 0, 500, 1, 2000); s_step = 50; cyc();
        s_en = 1; cyc(); ticks(4);
        s_flt = 1; cyc(); s_flt = 0; cyc();
        s_flt = 1; s_clr = 1; cyc(); cyc();
        s_flt = 0; cyc();
        s_en = 0; s_clr = 1; cyc(); cyc();

        // Tick and config in the same cycle with step 0.
        cfg(10, 0, 0, 0, 2000); s_step = 0; cyc();
        s_en = 1; cyc(); ticks(2); ticks(2);
        cfg(0, 0, 0, 0, 2000); s_tk = 1; cyc(); cyc();
        ticks(4);

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) s_en = ~s_en;
            s_flt = ($urandom_range(0, 199) == 0);
            s_clr = ($urandom_range(0, 9) == 0);
            s_tk  = ($urandom_range(0, 3) == 0);
            s_rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 7) == 0)
                cfg($urandom_range(0, 2600), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2600), 1'($urandom_range(0, 1)),
                    $urandom_range(300, 3000));
            if ($urandom_range(0, 31) == 0) s_step = $urandom_range(0, 255);
            cyc();
        end

        s_en = 0; s_flt = 0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
        #2;
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
